prescaled_updown_counter: RTL and testbench
===========================================

# prescaled_updown_counter

Parametrised binary up/down counter with a synchronous prescaler, programmable modulus, parallel load and a terminal-count pulse. It is the general counter primitive for board-level display and timing designs. It runs entirely in the `clk` domain and uses a clock-enable tick, never a derived clock. The counter drives LED/segment decoders directly and chains to further counters through `tc`.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits.
- `MODULO`, default 16: count range is 0..MODULO-1. Legal values are 2..2^WIDTH.
- `PRESC_W`, default 26: prescaler width in bits.

Ports:
- `clk`  input  1: clock; all state changes on the rising edge.
- `reset`  input  1: synchronous, active-low reset.
- `en`  input  1: count enable; low freezes both the prescaler and the counter.
- `up_dn`  input  1: 1 = count up, 0 = count down.
- `load`  input  1: parallel load strobe.
- `load_val`  input  WIDTH: value to load.
- `presc_div`  input  PRESC_W: tick period is presc_div+1 clk cycles.
- `count`  output  WIDTH: registered count value.
- `tc`  output  1: registered one-cycle pulse on wrap-around.

## Operation
- Priority on each rising edge: reset > load > step > hold.
- Reset (`reset`==0): `count`=0, `tc`=0, prescaler=0.
- Prescaler:
  - `presc` counts 0..presc_div while `en`=1, then returns to 0.
  - Internal `step` = `en` && (`presc`==`presc_div`).
  - If `presc_div` is lowered below the current `presc`, `presc` increments to its all-ones value, wraps to 0 and resumes. No step is issued during this recovery.
- Load (`load`==1):
  - `count` = `load_val`, clamped to MODULO-1 when `load_val` >= MODULO.
  - Prescaler clears to 0 and `tc`=0.
  - Load acts regardless of `en`.
- Step, up direction: `count`+1, or 0 with `tc`=1 when `count`==MODULO-1.
- Step, down direction: `count`-1, or MODULO-1 with `tc`=1 when `count`==0.
- All other cycles: `count` holds and `tc`=0.
- `up_dn` is sampled only on step cycles. A direction change takes effect at the next step with no extra latency.
- Arithmetic is WIDTH bits wide. `count` never leaves 0..MODULO-1, including when MODULO=2^WIDTH.

## Timing
- Step latency:
  - From reset or load, with `en`=1 held and `presc_div`=D, the first step lands on the (D+1)th rising edge.
  - Subsequent steps occur every D+1 edges.
  - `count` shows the new value immediately after that edge.
- `presc_div`=0 steps on every edge while `en`=1.
- `tc` is high for exactly one clk cycle, coincident with the wrapped `count` value. It is never asserted by load or reset.
- Deasserting `en` mid-period freezes `presc`. Reasserting it resumes from the frozen phase; the period does not restart.
- Reset mid-period discards prescaler phase and count on the same edge.
- Load and step in the same cycle: load wins, no `tc`, and the prescaler restarts.

## Configuration
- Macro: `PRESCALED_UPDOWN_COUNTER_PRESCALER_EN`.
- Defined: the prescaler behaves as described above, and `presc_div` sets the step rate.
- Undefined:
  - The prescaler logic is not compiled, and `step` = `en`, so the counter steps on every enabled edge.
  - `presc_div` is ignored but remains on the port list.
  - All other behaviour, including `tc`, load and priority, is unchanged.

## Test plan
- **Reset and count-up:** reset=0 for 2 cycles, then reset=1, en=1, up_dn=1, presc_div=3. Required: count=0 after reset; count=1 at edge 4, count=2 at edge 8; count=15 then 0 with tc=1 for one cycle at edge 64.
- **Down count and modulo wrap:** MODULO=10, load_val=0, load pulse, then up_dn=0, presc_div=0. Required: count goes 0 -> 9 with tc=1 on the first edge, then 8, 7, ...
- **Load clamp and priority:** MODULO=10, load=1 with load_val=13 on a step cycle. Required: count=9, tc=0, prescaler restarts so the next step comes presc_div+1 edges later.
- **Enable freeze:** presc_div=5, en dropped after 3 edges for 10 cycles, then restored. Required: count unchanged while en=0; first step 3 edges after re-enable.
- **Mid-operation reset:** count=7, direction down, reset=0 for one edge. Required: count=0, tc=0 on that edge, and the full D+1 edge latency before the next step.
- **Macro undefined:** presc_div=100, en=1, up_dn=1. Required: count increments on every edge; wrap 15 -> 0 with tc=1 at edge 16.

Source files
------------

// File: rtl/prescaled_updown_counter.sv
// Binary up/down counter with a clock-enable prescaler, programmable modulus, clamped parallel load and tc pulse.
// Define PRESCALED_UPDOWN_COUNTER_PRESCALER_EN to compile the prescaler; otherwise every enabled edge is a step.
module prescaled_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULO  = 16,
  parameter int PRESC_W = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               up_dn,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [PRESC_W-1:0] presc_div,
  output logic [WIDTH-1:0]   count,
  output logic               tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic step;

`ifdef PRESCALED_UPDOWN_COUNTER_PRESCALER_EN
  logic [PRESC_W-1:0] presc;

  // A presc above a freshly lowered presc_div runs on to all-ones and wraps through 0 without a step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
    end else if (load) begin
      presc <= '0;
    end else if (en) begin
      if (presc == presc_div) presc <= '0;
      else                    presc <= presc + 1'b1;
    end
  end

  assign step = en && (presc == presc_div);
`else
  logic unused_presc_div;

  assign unused_presc_div = ^presc_div;
  assign step             = en;
`endif

  // Clamping against MAX_VAL keeps count in range even when MODULO == 2**WIDTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= (load_val > MAX_VAL) ? MAX_VAL : load_val;
      tc    <= 1'b0;
    end else if (step) begin
      if (up_dn) begin
        if (count == MAX_VAL) begin
          count <= '0;
          tc    <= 1'b1;
        end else begin
          count <= count + 1'b1;
          tc    <= 1'b0;
        end
      end else begin
        if (count == '0) begin
          count <= MAX_VAL;
          tc    <= 1'b1;
        end else begin
          count <= count - 1'b1;
          tc    <= 1'b0;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Bench for prescaled_updown_counter: two instances (MODULO 16 and 10) share one stimulus stream;
// per-edge expectations go into exp_q and a negedge monitor pops and compares them.
module tb_prescaled_updown_counter;

  localparam int W  = 4;
  localparam int PW = 8;
  localparam int EW = 17;
`ifdef PRESCALED_UPDOWN_COUNTER_PRESCALER_EN
  localparam bit PRESC_ON = 1'b1;
`else
  localparam bit PRESC_ON = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          up_dn = 1'b1;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [PW-1:0] presc_div = '0;
  logic [W-1:0]  count16, count10;
  logic          tc16, tc10;

  always #5 clk = ~clk;

  prescaled_updown_counter #(.WIDTH(W), .MODULO(16), .PRESC_W(PW)) dut16 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .presc_div(presc_div), .count(count16), .tc(tc16)
  );

  prescaled_updown_counter #(.WIDTH(W), .MODULO(10), .PRESC_W(PW)) dut10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .presc_div(presc_div), .count(count10), .tc(tc10)
  );

  // ---------------- scoreboard state ----------------
  // Entry: [16:15] hand-check select (1=dut16, 2=dut10), [14:11] hand count, [10] hand tc,
  //        [9:6] model count16, [5] model tc16, [4:1] model count10, [0] model tc10.
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  int m_presc = 0;
  int m_c16 = 0, m_c10 = 0;
  bit m_t16 = 1'b0, m_t10 = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_count(inout int c, output bit t, input int m);
    t = 1'b0;
    if (up_dn) begin
      if (c == m - 1) begin c = 0; t = 1'b1; end
      else c = c + 1;
    end else begin
      if (c == 0) begin c = m - 1; t = 1'b1; end
      else c = c - 1;
    end
  endtask

  task automatic model_update();
    bit stp;
    stp = en && (!PRESC_ON || (m_presc == int'(presc_div)));
    if (!reset) begin
      m_presc = 0; m_c16 = 0; m_c10 = 0; m_t16 = 1'b0; m_t10 = 1'b0;
    end else if (load) begin
      m_presc = 0;
      m_c16 = (int'(load_val) > 15) ? 15 : int'(load_val);
      m_c10 = (int'(load_val) > 9) ? 9 : int'(load_val);
      m_t16 = 1'b0; m_t10 = 1'b0;
    end else begin
      if (PRESC_ON && en)
        m_presc = (m_presc == int'(presc_div)) ? 0 : (m_presc + 1) % (1 << PW);
      if (stp) begin
        model_count(m_c16, m_t16, 16);
        model_count(m_c10, m_t10, 10);
      end else begin
        m_t16 = 1'b0; m_t10 = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change at negedge; one call = one rising edge plus its expected result.
  task automatic tick(input int hsel = 0, input int hc = 0, input bit ht = 1'b0);
    @(posedge clk);
    #1;
    model_update();
    exp_q.push_back({2'(hsel), 4'(hc), ht, 4'(m_c16), m_t16, 4'(m_c10), m_t10});
    @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = W'(v);
    tick();
    load = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("count16", int'(count16), int'(e[9:6]));
      check("tc16",    int'(tc16),    int'(e[5]));
      check("count10", int'(count10), int'(e[4:1]));
      check("tc10",    int'(tc10),    int'(e[0]));
      if (e[16:15] == 2'd1) begin
        check("hand count16", int'(count16), int'(e[14:11]));
        check("hand tc16",    int'(tc16),    int'(e[10]));
      end else if (e[16:15] == 2'd2) begin
        check("hand count10", int'(count10), int'(e[14:11]));
        check("hand tc10",    int'(tc10),    int'(e[10]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; en = 1'b0;
    tick(1, 0, 0);
    tick(2, 0, 0);

`ifdef PRESCALED_UPDOWN_COUNTER_PRESCALER_EN
    // Count up with a 4-edge period: 1 at edge 4, 2 at edge 8, wrap at edge 64.
    reset = 1'b1; en = 1'b1; up_dn = 1'b1; presc_div = 3;
    for (int i = 1; i <= 65; i++) begin
      if (i == 4)       tick(1, 1, 0);
      else if (i == 8)  tick(1, 2, 0);
      else if (i == 60) tick(1, 15, 0);
      else if (i == 63) tick(1, 15, 0);
      else if (i == 64) tick(1, 0, 1);
      else if (i == 65) tick(1, 0, 0);
      else              tick();
    end

    // Down count with modulo-10 wrap, stepping every edge.
    load = 1'b1; load_val = 0;
    tick(2, 0, 0);
    load = 1'b0; up_dn = 1'b0; presc_div = 0;
    tick(2, 9, 1);
    tick(2, 8, 0);
    tick(2, 7, 0);
    repeat (8) tick();

    // Clamped load on what would be a step edge; prescaler restarts.
    presc_div = 3; up_dn = 1'b1;
    do_load(0);
    repeat (3) tick();
    load = 1'b1; load_val = 13;
    tick(2, 9, 0);
    load = 1'b0;
    tick(1, 13, 0);
    tick(1, 13, 0);
    tick(1, 13, 0);
    tick(1, 14, 0);

    // Enable freeze mid-period and resume from the frozen phase.
    presc_div = 5;
    do_load(0);
    repeat (3) tick();
    en = 1'b0;
    repeat (10) tick(1, 0, 0);
    en = 1'b1;
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 1, 0);

    // Reset mid-period discards phase; full 3-edge latency afterwards.
    presc_div = 2;
    do_load(7);
    up_dn = 1'b0;
    tick(1, 7, 0);
    tick(1, 7, 0);
    reset = 1'b0;
    tick(1, 0, 0);
    reset = 1'b1;
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 15, 1);

    // Lowering presc_div below presc: run to all-ones, wrap, then resume.
    up_dn = 1'b1; presc_div = 7;
    do_load(0);
    repeat (5) tick();
    presc_div = 2;
    for (int i = 1; i <= 254; i++) begin
      if (i == 253)      tick(1, 0, 0);
      else if (i == 254) tick(1, 1, 0);
      else               tick();
    end
`else
    // No prescaler: every enabled edge steps; wrap 15 -> 0 at edge 16.
    reset = 1'b1; en = 1'b1; up_dn = 1'b1; presc_div = 100;
    for (int i = 1; i <= 17; i++) begin
      if (i == 1)       tick(1, 1, 0);
      else if (i == 10) tick(2, 0, 1);
      else if (i == 15) tick(1, 15, 0);
      else if (i == 16) tick(1, 0, 1);
      else if (i == 17) tick(1, 1, 0);
      else              tick();
    end

    // Clamped load wins over the step.
    load = 1'b1; load_val = 13;
    tick(2, 9, 0);
    load = 1'b0;
    tick(2, 0, 1);
    tick(1, 15, 0);

    // Down direction, freeze, mid-run reset.
    up_dn = 1'b0;
    do_load(0);
    tick(1, 15, 1);
    tick(1, 14, 0);
    en = 1'b0;
    repeat (3) tick(1, 14, 0);
    en = 1'b1;
    reset = 1'b0;
    tick(1, 0, 0);
    reset = 1'b1;
    tick(1, 15, 1);
    tick(2, 8, 0);
`endif

    en = 1'b0;
    repeat (2) @(negedge clk);
    check("queue drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
